// File: rtl/riscv_v_pkg.sv
// riscv_v_pkg: shared widths, exe control bundle and sequencer state encoding
package riscv_v_pkg;
  localparam int RISCV_V_DATA_WIDTH = 128;
  localparam int RISCV_V_NUM_BYTES_DATA = 16;
  localparam int VDATA_W = RISCV_V_DATA_WIDTH + RISCV_V_NUM_BYTES_DATA;
  localparam int NUM_BYTES = RISCV_V_NUM_BYTES_DATA;
  localparam int VRES_W = VDATA_W - NUM_BYTES;
  localparam int MUL_LAT_DEF = 3;
  typedef struct packed {
    logic [1:0]  osize;
    logic [7:0]  opcode;
    logic [5:0]  len;
    logic [15:0] imm;
    logic        is_signed;
    logic        is_sat;
    logic        is_mask;
    logic        is_red;
    logic        is_v2i;
    logic        is_mul;
    logic        is_widen;
    logic        is_narrow;
    logic [7:0]  rsvd;
  } exe_ctrl_t;
  localparam int CTRL_W = $bits(exe_ctrl_t);
  typedef enum logic [1:0] {IDLE, EXEC, WB} exe_state_e;
  function automatic int cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction
endpackage

// File: rtl/riscv_v_exe_ctrl_if.sv
// riscv_v_exe_ctrl_if: decode, ALU and writeback signals of the vector exe sequencer
interface riscv_v_exe_ctrl_if;
  import riscv_v_pkg::*;
  logic                 id_valid;
  logic                 id_ready;
  logic [CTRL_W-1:0]    id_ctrl;
  logic                 id_is_mul;
  logic                 id_is_v2i;
  logic [VDATA_W-1:0]   id_srca;
  logic [VDATA_W-1:0]   id_srcb;
  logic [NUM_BYTES-1:0] id_mask;
  logic [4:0]           id_dst;
  logic                 flush;
  logic [CTRL_W-1:0]    alu_ctrl;
  logic [VDATA_W-1:0]   alu_srca;
  logic [VDATA_W-1:0]   alu_srcb;
  logic [NUM_BYTES-1:0] alu_mask;
  logic [VRES_W-1:0]    alu_vec_result;
  logic [31:0]          alu_int_result;
  logic                 wb_vec_valid;
  logic                 wb_vec_ready;
  logic [VRES_W-1:0]    wb_vec_data;
  logic                 wb_int_valid;
  logic                 wb_int_ready;
  logic [31:0]          wb_int_data;
  logic [4:0]           wb_dst;
  logic                 busy;
  modport slave (
    input  id_valid, id_ctrl, id_is_mul, id_is_v2i, id_srca, id_srcb, id_mask, id_dst, flush,
    input  alu_vec_result, alu_int_result, wb_vec_ready, wb_int_ready,
    output id_ready, alu_ctrl, alu_srca, alu_srcb, alu_mask,
    output wb_vec_valid, wb_vec_data, wb_int_valid, wb_int_data, wb_dst, busy
  );
  modport master (
    output id_valid, id_ctrl, id_is_mul, id_is_v2i, id_srca, id_srcb, id_mask, id_dst, flush,
    output alu_vec_result, alu_int_result, wb_vec_ready, wb_int_ready,
    input  id_ready, alu_ctrl, alu_srca, alu_srcb, alu_mask,
    input  wb_vec_valid, wb_vec_data, wb_int_valid, wb_int_data, wb_dst, busy
  );
endinterface

// File: rtl/riscv_v_exe_ctrl.sv
// riscv_v_exe_ctrl: single-issue vector exe sequencer with multi-cycle multiply and held writeback
module riscv_v_exe_ctrl
  import riscv_v_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input logic               clk,
  input logic               rst,
  riscv_v_exe_ctrl_if.slave bus
);
  localparam int CNT_W = cnt_w(MUL_LAT);
  exe_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CTRL_W-1:0]    ctrl_q;
  logic [VDATA_W-1:0]   srca_q, srcb_q;
  logic [NUM_BYTES-1:0] mask_q;
  logic [4:0]           dst_q;
  logic                 v2i_q;
  logic                 vec_vld_q, vec_vld_d, int_vld_q, int_vld_d;
  logic [VRES_W-1:0]    vec_data_q;
  logic [31:0]          int_data_q;
  logic                 accept, capture, done;
  assign bus.id_ready = (state_q == IDLE) & ~bus.flush & ~rst;
  assign accept = bus.id_valid & bus.id_ready;
  assign capture = (state_q == EXEC) & (cnt_q == '0) & ~bus.flush;
  assign done = (vec_vld_q & bus.wb_vec_ready) | (int_vld_q & bus.wb_int_ready);
  assign bus.alu_ctrl = ctrl_q;
  assign bus.alu_srca = srca_q;
  assign bus.alu_srcb = srcb_q;
  assign bus.alu_mask = mask_q;
  assign bus.wb_vec_valid = vec_vld_q;
  assign bus.wb_vec_data = vec_data_q;
  assign bus.wb_int_valid = int_vld_q;
  assign bus.wb_int_data = int_data_q;
  assign bus.wb_dst = dst_q;
  assign bus.busy = state_q != IDLE;
  // next state: flush returns to IDLE from anywhere and drops any pending result
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    vec_vld_d = vec_vld_q;
    int_vld_d = int_vld_q;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d = '0;
      vec_vld_d = 1'b0;
      int_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_d = EXEC;
          cnt_d = bus.id_is_mul ? CNT_W'(MUL_LAT - 1) : '0;
        end
        EXEC: if (cnt_q == '0) begin
          state_d = WB;
          vec_vld_d = ~v2i_q;
          int_vld_d = v2i_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        WB: if (done) begin
          state_d = IDLE;
          vec_vld_d = 1'b0;
          int_vld_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // control state and writeback valids
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vec_vld_q <= 1'b0;
      int_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vec_vld_q <= vec_vld_d;
      int_vld_q <= int_vld_d;
    end
  end
  // operand registers load on accept and stay put until the next accept; result registers load at end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      srca_q <= '0;
      srcb_q <= '0;
      mask_q <= '0;
      dst_q <= '0;
      v2i_q <= 1'b0;
      vec_data_q <= '0;
      int_data_q <= '0;
    end else begin
      if (accept) begin
        ctrl_q <= bus.id_ctrl;
        srca_q <= bus.id_srca;
        srcb_q <= bus.id_srcb;
        mask_q <= bus.id_mask;
        dst_q <= bus.id_dst;
        v2i_q <= bus.id_is_v2i;
      end
      if (capture) begin
        vec_data_q <= v2i_q ? vec_data_q : bus.alu_vec_result;
        int_data_q <= v2i_q ? bus.alu_int_result : int_data_q;
      end
    end
  end
endmodule

// File: doc/riscv_v_exe_ctrl.md
Name: riscv_v_exe_ctrl

Overview:
Single-issue sequencer for the vector execute stage. Accepts decoded vector ops from decode over a valid/ready handshake and holds operands/control stable in exe registers for the combinational vector ALU. Multiplies get a multi-cycle path; all other ops get a single cycle. The block captures the ALU vector/integer result and presents it to vector or integer writeback with backpressure.

Parameters:
VDATA_W, 144, vector operand width (128 data + 16 per-byte tag bits)
NUM_BYTES, 16, elements/mask bits per register
CTRL_W, 48, width of packed decoded control bundle (osize, opcode, len, is_* flags)
MUL_LAT, 3, exe cycles held for is_mul ops (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  decode has an op
id_ready  out  1  controller accepts op this cycle
id_ctrl  in  CTRL_W  decoded control bundle
id_is_mul  in  1  op uses multiplier
id_is_v2i  in  1  result goes to integer RF; else vector RF
id_srca  in  VDATA_W  source A
id_srcb  in  VDATA_W  source B
id_mask  in  NUM_BYTES  mask/carry-in
id_dst  in  5  destination register index
flush  in  1  kill in-flight op
alu_ctrl  out  CTRL_W  registered control to ALU
alu_srca  out  VDATA_W  registered source A
alu_srcb  out  VDATA_W  registered source B
alu_mask  out  NUM_BYTES  registered mask
alu_vec_result  in  VDATA_W-NUM_BYTES  ALU vector result
alu_int_result  in  32  ALU integer result
wb_vec_valid  out  1  vector writeback pending
wb_vec_ready  in  1  vector RF accepts
wb_vec_data  out  VDATA_W-NUM_BYTES  vector result
wb_int_valid  out  1  integer writeback pending
wb_int_ready  in  1  integer RF accepts
wb_int_data  out  32  integer result
wb_dst  out  5  destination index
busy  out  1  state != IDLE

Behaviour:
- States IDLE, EXEC, WB. Reset (rst=1 at posedge): state IDLE, all outputs 0, id_ready=0 during reset cycle, exe/wb registers cleared, counter 0.
- id_ready = (state==IDLE) & ~flush. Accept = id_valid & id_ready.
- IDLE: on accept, latch id_ctrl/srca/srcb/mask/dst/is_v2i into alu_* regs; counter loads (id_is_mul ? MUL_LAT-1 : 0); -> EXEC.
- EXEC: alu_* held stable. If counter==0, capture alu_vec_result or alu_int_result (per is_v2i) into wb regs, raise wb_vec_valid or wb_int_valid (never both), -> WB. Else decrement.
- WB: valid held, data/dst stable until matching ready. On ready: drop valid, -> IDLE. No accept in WB (next op accepted the following cycle in IDLE).
- Latency accept->wb_valid: 2 cycles non-mul, MUL_LAT+1 for mul. Throughput: one op per 3 cycles minimum.
- flush: in any state, next cycle state IDLE, wb valids 0, counter 0; in-flight result discarded; flush with id_valid in IDLE does not accept. flush dominates ready in WB (no handshake completion reported).
- rst dominates flush and accept.
- alu_* regs retain last values in IDLE (no toggling), cleared only by rst.
- MUL_LAT=1 behaves identically to non-mul.

Decomposition:
- Package riscv_v_pkg: exe ctrl bundle struct (osize, opcode, len, is_* flags) and CTRL_W derivation, state enum, VDATA_W from RISCV_V_DATA_WIDTH + RISCV_V_NUM_BYTES_DATA.
- No sub-module needed; optional riscv_v_wb_reg (valid/ready holding register) if reused by load unit.

Test Plan:
- Reset: rst=1 two cycles with id_valid=1 -> id_ready=0, wb_*_valid=0, busy=0; release -> id_ready=1 next cycle.
- Non-mul vector op accepted cycle 0, alu_vec_result=0x...A5, wb_vec_ready=1 -> wb_vec_valid=1 only in cycle 2, data 0xA5 pattern, wb_dst matches, id_ready=1 cycle 3.
- Mul op, MUL_LAT=3 -> wb_vec_valid first asserted cycle 4; alu_srca unchanged cycles 1-3.
- v2i op, alu_int_result=0x1234_5678, wb_int_ready low 5 cycles -> wb_int_valid held, data stable, wb_vec_valid=0, id_ready=0 throughout; accepted on ready.
- flush asserted in EXEC of mul op -> next cycle IDLE, no wb_valid ever for that op; subsequent op completes normally.
- flush and id_valid same cycle in IDLE -> not accepted, busy stays 0.
